// File: rtl/skip_ctrl.sv
// skip_ctrl: annuls the instruction that follows a live skip in execute.
// Waits across bubbles and stalls, yields to taken jumps.
module skip_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             dec_valid,
   input  logic             ex_valid,
   input  logic             skip_req,
   input  logic             jump_req,
   input  logic             cnt_clr,
   output logic             ex_annul,
   output logic             skip_pending,
   output logic             skip_taken,
   output logic [CNT_W-1:0] annul_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic adv;
   logic ex_live;
   logic eff_jump;
   logic eff_skip;
   logic annul_nxt;

   // qualify requests: an annulled instruction neither skips nor jumps
   always_comb begin
      adv      = !stall;
      ex_live  = ex_valid && !ex_annul;
      eff_jump = ex_live && jump_req;
      eff_skip = ex_live && skip_req && !jump_req;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state: arm when the skip finds no victim in decode
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (eff_skip && adv && !dec_valid)
               state_nxt = ARMED;
         end
         ARMED: begin
            if (adv && eff_jump)
               state_nxt = IDLE;
            else if (adv && dec_valid)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs and next annul value
   always_comb begin
      skip_pending = (state == ARMED);
      skip_taken   = eff_skip && adv;
      annul_nxt    = dec_valid && !eff_jump
                   && (eff_skip || (state == ARMED));
   end

   // annul flag follows its victim through stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_annul <= 1'b0;
      end else if (adv) begin
         ex_annul <= annul_nxt;
      end
   end

   // count annulled instructions; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         annul_cnt <= '0;
      end else if (cnt_clr) begin
         annul_cnt <= '0;
      end else if (adv && annul_nxt) begin
         annul_cnt <= annul_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/skip_ctrl.md
# skip_ctrl

Pipeline annul controller for the ez8 core: it is the consumer of the skip decision produced in the execute stage. When an executing skip instruction (skeqz…sklez, skbs, skbc) resolves true, `skip_ctrl` annuls exactly the next instruction to enter execute. It waits across fetch bubbles and pipeline stalls as needed, and it yields to taken jumps. It sits beside the pipeline register between decode and execute and drives the annul flag that downstream logic uses to suppress register writes, accumulator writes, memory writes and control-flow effects.

## Interface
Parameters:
- `CNT_W`, default 8, width of the annulled-instruction counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  pipeline hold. While high, the decode→execute register does not advance.
- `dec_valid`  in  1  the decode stage holds a valid instruction.
- `ex_valid`  in  1  the execute stage holds a valid instruction.
- `skip_req`  in  1  skip condition from the skip calculation logic; meaningful only with `ex_valid`.
- `jump_req`  in  1  taken jump, call or return in execute; the pipeline flushes decode on it.
- `cnt_clr`  in  1  synchronous clear of `annul_cnt`.
- `ex_annul`  out  1  registered; the instruction now in execute is annulled.
- `skip_pending`  out  1  a skip is armed and waiting for a valid instruction (state ARMED).
- `skip_taken`  out  1  combinational pulse; an effective skip is being committed this cycle.
- `annul_cnt`  out  CNT_W  number of instructions annulled since reset or clear; wraps.

## Operation
Definitions:
- `adv = !stall`.
- `ex_live = ex_valid && !ex_annul`. An annulled instruction never skips and never jumps.
- `eff_jump = ex_live && jump_req`.
- `eff_skip = ex_live && skip_req && !jump_req`. Jump has priority over skip.
- `skip_taken = eff_skip && adv`.

State machine with two states, IDLE and ARMED.

IDLE:
- `eff_skip && adv && dec_valid` → stay IDLE. The next `ex_annul` is 1, so the decode instruction is killed as it advances.
- `eff_skip && adv && !dec_valid` → ARMED.
- Otherwise → stay IDLE.

ARMED:
- `eff_jump && adv` → IDLE. The armed skip is cancelled because the jump target must not be annulled. This case cannot occur through a live instruction because ARMED implies execute is empty or annulled; it is handled defensively.
- `adv && dec_valid` → IDLE, and the next `ex_annul` is 1.
- `adv && !dec_valid` → stay ARMED.
- `stall` → hold.

`ex_annul` register:
- On `adv`: `ex_annul <= dec_valid && !eff_jump && (eff_skip || state==ARMED)`.
- On `stall`: hold.

`annul_cnt`:
- Increments by 1 on each edge where the `ex_annul` next-value is 1 and `adv` is high.
- 255+1 → 0.
- `cnt_clr` takes priority over increment.

Chained skips: a skip instruction that has been annulled does not skip, so at most one instruction is killed per live skip.

## Timing
Reset values, applied asynchronously on `rst_n` low:
- `ex_annul` = 0
- state = IDLE, so `skip_pending` = 0
- `annul_cnt` = 0
- `skip_taken` follows its inputs (0 when `ex_valid` = 0).

Release of `rst_n` is synchronous to `clk` (handled upstream). Reset mid-ARMED discards the pending skip.

Latency: the skip resolves in cycle N with `adv`, and `ex_annul` = 1 from cycle N+1 for as long as the victim sits in execute. If the victim is stalled there, `ex_annul` stays 1 through the stall.

A stall while `eff_skip` is asserted defers all action. The skip commits on the first cycle with `adv` high, and `skip_taken` pulses exactly once.

`skip_pending` is high for every cycle spent in ARMED.

`ex_annul` deasserts on the first advance after the victim leaves execute, unless the next instruction is itself annulled. That case cannot arise, since an annulled instruction cannot skip.

## Test plan
- **Basic skip.** `ex_valid`=1, `skip_req`=1, `dec_valid`=1, no stall at cycle 5 → `skip_taken`=1 at 5; `ex_annul`=1 at 6; `annul_cnt`=1; `skip_pending` never set.
- **Bubble.** Skip at cycle 5 with `dec_valid`=0 for cycles 5–7, `dec_valid`=1 at cycle 8 → `skip_pending`=1 for cycles 6–8; `ex_annul`=1 at 9 only; IDLE at 9.
- **Stall.** Skip resolves at cycle 5 with `stall`=1 for cycles 5–7 → `skip_taken` pulses once at 8; `ex_annul`=1 from 9 and held while `stall` is high at 9–10; `annul_cnt` increments once.
- **Priority and chaining.** `skip_req`=1 and `jump_req`=1 together → `skip_taken`=0, next `ex_annul`=0. An annulled instruction with `skip_req`=1 → no skip; the instruction after it executes with `ex_annul`=0.
- **Counter and reset.** 256 skips → `annul_cnt` wraps to 0. `cnt_clr` coinciding with an annul → 0. `rst_n` low asynchronously in ARMED → `skip_pending`=0 and `ex_annul`=0 immediately, without a clock edge.
